// File: rtl/alu_pkg.sv
// Shared definitions for the slice-serial ALU flag unit: flag bit positions
// inside the architectural flag register and the accumulation FSM encoding.
package alu_pkg;

    localparam int FLAG_W  = 8;

    localparam int FLAG_Z  = 0;
    localparam int FLAG_C  = 1;
    localparam int FLAG_E  = 2;
    localparam int FLAG_LT = 3;
    localparam int FLAG_GT = 4;
    localparam int FLAG_N  = 5;
    localparam int FLAG_V  = 6;
    localparam int FLAG_SV = 7;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

endpackage : alu_pkg

// File: rtl/alu_flag_calc.sv
// Combinational final-slice flag computation. Combines the running accumulators
// with the current (last) slice; the sticky bit is left to the flag register.
module alu_flag_calc
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic              z_acc,
    input  logic              e_acc,
    input  logic              cin0_n,
    input  logic              sub,
    input  logic [W-1:0]      f,
    input  logic              a_b,
    input  logic              cn8_n,
    input  logic              a_msb,
    input  logic              b_msb,
    output logic [FLAG_W-1:0] flags_o
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        flags_o           = '0;
        flags_o[FLAG_Z]   = z_acc & ~|f;
        flags_o[FLAG_C]   = ~cn8_n;
        flags_o[FLAG_E]   = e_acc & a_b;
        flags_o[FLAG_LT]  = ~cin0_n & cn8_n;
        flags_o[FLAG_GT]  = cin0_n & ~cn8_n;
        flags_o[FLAG_N]   = f[W-1];
        // Operands of like sign (after subtract inversion) producing a result of the other sign.
        flags_o[FLAG_V]   = (a_msb ~^ (b_msb ^ sub)) & (f[W-1] ^ a_msb);
    end

endmodule : alu_flag_calc

// File: rtl/alu_flags_seq.sv
// Registered flag unit: accumulates per-slice ALU status over one wide operation
// and commits masked flags on the last slice, with software load and sticky overflow.
module alu_flags_seq
    import alu_pkg::*;
#(
    parameter int W          = 8,
    parameter int MAX_SLICES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_first,
    input  logic              in_last,
    input  logic [W-1:0]      f,
    input  logic              a_b,
    input  logic              cn_n,
    input  logic              cn8_n,
    input  logic              a_msb,
    input  logic              b_msb,
    input  logic              sub,
    input  logic [FLAG_W-1:0] upd_mask,
    input  logic              flags_we,
    input  logic [FLAG_W-1:0] flags_wdata,
    input  logic              clr_sticky,
    output logic [FLAG_W-1:0] flags,
    output logic              flags_valid,
    output logic              busy,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(MAX_SLICES + 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                z_acc_q, z_acc_d;
    logic                e_acc_q, e_acc_d;
    logic                cin0_q, cin0_d;
    logic                sub_q, sub_d;
    logic [FLAG_W-1:0]   mask_q, mask_d;
    logic [FLAG_W-1:0]   flags_q, flags_d;
    logic                flags_valid_q, flags_valid_d;
    logic                frame_err_q, frame_err_d;

    logic                commit;
    logic                err;
    logic                in_op;
    logic [FLAG_W-1:0]   calc_flags;
    logic [FLAG_W-1:0]   eff_mask;

    // A single-slice op commits straight from IDLE, so it uses the live first-slice inputs.
    assign in_op    = (state_q == ST_ACCUM);
    assign eff_mask = in_op ? mask_q : upd_mask;

    alu_flag_calc #(.W(W)) u_calc (
        .z_acc   (in_op ? z_acc_q : 1'b1),
        .e_acc   (in_op ? e_acc_q : 1'b1),
        .cin0_n  (in_op ? cin0_q  : cn_n),
        .sub     (in_op ? sub_q   : sub),
        .f       (f),
        .a_b     (a_b),
        .cn8_n   (cn8_n),
        .a_msb   (a_msb),
        .b_msb   (b_msb),
        .flags_o (calc_flags)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        z_acc_d = z_acc_q;
        e_acc_d = e_acc_q;
        cin0_d  = cin0_q;
        sub_d   = sub_q;
        mask_d  = mask_q;
        commit  = 1'b0;
        err     = 1'b0;

        if (in_valid) begin
            if (!in_op) begin
                if (!in_first)
                    err = 1'b1;
                else if (in_last)
                    commit = 1'b1;
                else if (MAX_SLICES == 1)
                    err = 1'b1;
                else begin
                    state_d = ST_ACCUM;
                    cnt_d   = CNT_W'(1);
                    z_acc_d = ~|f;
                    e_acc_d = a_b;
                    cin0_d  = cn_n;
                    sub_d   = sub;
                    mask_d  = upd_mask;
                end
            end else begin
                if (in_first)
                    err = 1'b1;
                else if (in_last)
                    commit = 1'b1;
                else if (cnt_q == CNT_W'(MAX_SLICES - 1))
                    err = 1'b1;
                else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    z_acc_d = z_acc_q & ~|f;
                    e_acc_d = e_acc_q & a_b;
                end
            end
        end

        if (commit || err) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            z_acc_d = 1'b0;
            e_acc_d = 1'b0;
            cin0_d  = 1'b0;
            sub_d   = 1'b0;
            mask_d  = '0;
        end

        flags_d = flags_q;
        if (commit) begin
            for (int i = 0; i < FLAG_SV; i++)
                if (eff_mask[i])
                    flags_d[i] = calc_flags[i];
        end
        if (clr_sticky)
            flags_d[FLAG_SV] = 1'b0;
        if (commit && eff_mask[FLAG_SV] && calc_flags[FLAG_V])
            flags_d[FLAG_SV] = 1'b1;
        if (flags_we)
            flags_d = flags_wdata;

        flags_valid_d = commit & ~flags_we;
        frame_err_d   = err;
    end

    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            z_acc_q       <= 1'b0;
            e_acc_q       <= 1'b0;
            cin0_q        <= 1'b0;
            sub_q         <= 1'b0;
            mask_q        <= '0;
            flags_q       <= '0;
            flags_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            z_acc_q       <= z_acc_d;
            e_acc_q       <= e_acc_d;
            cin0_q        <= cin0_d;
            sub_q         <= sub_d;
            mask_q        <= mask_d;
            flags_q       <= flags_d;
            flags_valid_q <= flags_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign flags       = flags_q;
    assign flags_valid = flags_valid_q;
    assign busy        = in_op;
    assign frame_err   = frame_err_q;

endmodule : alu_flags_seq
